// File: rtl/mesh_result_reader.sv
// mesh_result_reader
//   Drains the finished result matrix out of the systolic mesh's unified SRAM
//   read port and presents it as an in-order valid/ready stream. Reads are
//   issued linearly (0..TOTAL-1) once the mesh reports collection complete.
//   Credit accounting (in-flight reads plus buffered words never exceed
//   FIFO_DEPTH) guarantees that every returned word has a buffer slot.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   start_i                  one-cycle drain request (honoured only in IDLE)
//   collection_complete_i    mesh has finished collecting results
//   mem_read_enable_o/addr_o registered read strobe and linear address
//   mem_read_data_i/valid_i  returned words, in issue order, variable latency
//   m_data_o/valid_o/ready_i output stream (FIFO head), m_last_o on final beat
//   busy_o                   high outside IDLE
//   done_o                   one-cycle pulse after the last beat is accepted
//   error_o                  sticky protocol error (unexpected or overflowing response)
module mesh_result_reader #(
    parameter int TILE_SIZE  = 8,
    parameter int TILES_X    = 4,
    parameter int TILES_Y    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int TOTAL  = TILE_SIZE * TILE_SIZE * TILES_X * TILES_Y,
    localparam int ADDR_W = $clog2(TOTAL)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  collection_complete_i,
    output logic                  mem_read_enable_o,
    output logic [ADDR_W-1:0]     mem_read_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i,
    input  logic                  mem_read_valid_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0]  DEPTH_S   = SUM_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_COLLECT,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W-1:0]   resp_cnt_q, resp_cnt_d;
    logic [CNT_W-1:0]    out_q, out_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_WIDTH:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0] head;

    logic                pop;
    logic                push;
    logic                resp_ok;
    logic                resp_last;
    logic                issue_go;
    logic [SUM_W-1:0]    used;

    assign head = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        resp_cnt_d  = resp_cnt_q;
        out_d       = out_q;
        fifo_cnt_d  = fifo_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;
        issue_go    = 1'b0;

        pop       = (fifo_cnt_q != '0) && m_ready_i;
        // Responses are only meaningful outside IDLE; late words after an
        // aborted run are silently dropped while idle.
        resp_ok   = mem_read_valid_i && (state_q != S_IDLE) && (out_q != '0);
        resp_last = (resp_cnt_q == LAST_ADDR);
        push      = resp_ok && ((fifo_cnt_q != DEPTH_C) || pop);

        // The read registered this cycle (en_q) is already committed, so it
        // consumes credit; a pop in this cycle frees one.
        used = SUM_W'(out_q) + SUM_W'(fifo_cnt_q) + SUM_W'(en_q) - SUM_W'(pop);

        if (mem_read_valid_i && (state_q != S_IDLE) && !push) begin
            err_d = 1'b1;
        end

        if (en_q && !resp_ok) begin
            out_d = out_q + CNT_W'(1);
        end else if (!en_q && resp_ok) begin
            out_d = out_q - CNT_W'(1);
        end

        if (resp_ok) begin
            resp_cnt_d = resp_cnt_q + ADDR_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_WAIT_COLLECT;
                    issue_cnt_d = '0;
                    resp_cnt_d  = '0;
                    out_d       = '0;
                    fifo_cnt_d  = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    err_d       = 1'b0;
                end
            end
            S_WAIT_COLLECT: begin
                if (collection_complete_i) begin
                    state_d  = S_ISSUE;
                    issue_go = (used < DEPTH_S);
                end
            end
            S_ISSUE: begin
                issue_go = (used < DEPTH_S);
            end
            S_DRAIN: begin
                if (pop && head[DATA_WIDTH] && (out_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_go) begin
            en_d   = 1'b1;
            addr_d = issue_cnt_q;
            if (issue_cnt_q == LAST_ADDR) begin
                state_d = S_DRAIN;
            end else begin
                issue_cnt_d = issue_cnt_q + ADDR_W'(1);
            end
        end
    end

    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            en_q        <= 1'b0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            out_q       <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            out_q       <= out_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {resp_last, mem_read_data_i};
        end
    end

    assign mem_read_enable_o = en_q;
    assign mem_read_addr_o   = addr_q;
    assign m_valid_o         = (fifo_cnt_q != '0);
    assign m_data_o          = m_valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign m_last_o          = m_valid_o & head[DATA_WIDTH];
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign error_o           = err_q;

endmodule

// File: tb/tb_mesh_result_reader.sv
// tb_mesh_result_reader
//   Directed bench for mesh_result_reader with TOTAL=16 (2x2 tiles of 2x2).
//   A small mesh model returns addr*3 after a configurable latency, in order.
//   A table of run configurations is applied in a loop; reset behaviour is
//   exercised by hand-written sequences.
module tb_mesh_result_reader;

    localparam int N     = 2;
    localparam int TX    = 2;
    localparam int TY    = 2;
    localparam int DW    = 32;
    localparam int FD    = 4;
    localparam int TOTAL = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic          collection_complete_i;
    logic          mem_read_enable_o;
    logic [AW-1:0] mem_read_addr_o;
    logic [DW-1:0] mem_read_data_i;
    logic          mem_read_valid_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    always #5 clk = ~clk;

    mesh_result_reader #(
        .TILE_SIZE (N),
        .TILES_X   (TX),
        .TILES_Y   (TY),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn_i),
        .start_i              (start_i),
        .collection_complete_i(collection_complete_i),
        .mem_read_enable_o    (mem_read_enable_o),
        .mem_read_addr_o      (mem_read_addr_o),
        .mem_read_data_i      (mem_read_data_i),
        .mem_read_valid_i     (mem_read_valid_i),
        .m_data_o             (m_data_o),
        .m_valid_o            (m_valid_o),
        .m_ready_i            (m_ready_i),
        .m_last_o             (m_last_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .error_o              (error_o)
    );

    typedef struct {
        int lmin;
        int lmax;
        bit rand_ready;
        int stall_from;
        int stall_len;
        bit spur;
        bit start_mid;
        bit exp_err;
        int exp_beats;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;

    // run-time model state
    int            cyc = 0;
    int            due_q[$];
    logic [DW-1:0] dat_q[$];
    int            last_due;
    int            lat_min, lat_max;
    bit            rand_ready;
    int            stall_from, stall_len, stall_cnt;
    bit            inject_spur, spur_done;
    int            issued, exp_addr, addr_err;
    int            beats, last_cnt, last_idx, last_cyc;
    logic [DW-1:0] got[$];
    int            done_cnt, done_cyc;
    logic          busy_at_done;
    int            max_inflight, stable_err, first_en_cyc;
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_model();
        due_q.delete();
        dat_q.delete();
        got.delete();
        last_due = 0; stall_cnt = 0; spur_done = 0;
        issued = 0; exp_addr = 0; addr_err = 0;
        beats = 0; last_cnt = 0; last_idx = -1; last_cyc = -1;
        done_cnt = 0; done_cyc = -1; busy_at_done = 1'b0;
        max_inflight = 0; stable_err = 0; first_en_cyc = -1;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    endtask

    // Advance one cycle, then (1 time unit after the edge) act as mesh and consumer.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_read_enable_o === 1'b1) begin
            int l;
            int d;
            l = $urandom_range(lat_max, lat_min);
            d = cyc + l;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            if (int'(mem_read_addr_o) != exp_addr) addr_err++;
            exp_addr++;
            issued++;
            due_q.push_back(d);
            dat_q.push_back(DW'(mem_read_addr_o) * 3);
        end
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_read_valid_i = 1'b1;
            mem_read_data_i  = dat_q.pop_front();
            void'(due_q.pop_front());
        end else if (inject_spur && !spur_done && mem_read_enable_o === 1'b1) begin
            mem_read_valid_i = 1'b1;
            mem_read_data_i  = 32'hDEAD_BEEF;
            spur_done        = 1'b1;
        end
        if (stall_len > 0 && beats >= stall_from && stall_cnt < stall_len) begin
            m_ready_i = 1'b0;
            stall_cnt++;
        end else begin
            m_ready_i = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        if (prev_stall && (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last))
            stable_err++;
        if (m_valid_o === 1'b1 && m_ready_i) begin
            got.push_back(m_data_o);
            if (m_last_o === 1'b1) begin
                last_cnt++;
                last_idx = beats;
                last_cyc = cyc;
            end
            beats++;
        end
        prev_stall = (m_valid_o === 1'b1) && !m_ready_i;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy_o;
        end
        if (issued - beats > max_inflight) max_inflight = issued - beats;
    endtask

    task automatic do_run(input vec_t v, input int idx);
        int k;
        int bad;
        string tag;
        bit pulsed;
        tag = $sformatf("run%0d", idx);
        clear_model();
        lat_min = v.lmin; lat_max = v.lmax; rand_ready = v.rand_ready;
        stall_from = v.stall_from; stall_len = v.stall_len; inject_spur = v.spur;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({tag, "_busy_after_start"}, busy_o, 1);
        check({tag, "_err_cleared_by_start"}, error_o, 0);
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_no_reads_while_waiting"}, issued, 0);
        check({tag, "_still_waiting_busy"}, busy_o, 1);
        k = cyc;
        collection_complete_i = 1'b1;
        pulsed = 1'b0;
        for (int i = 0; i < 600 && done_cnt == 0; i++) begin
            start_i = (v.start_mid && issued == 3 && !pulsed);
            if (start_i) pulsed = 1'b1;
            tick();
        end
        start_i = 1'b0;
        collection_complete_i = 1'b0;
        tick();
        check({tag, "_idle_after_done"}, busy_o, 0);
        tick();
        check({tag, "_first_read_cycle"}, first_en_cyc, k + 1);
        check({tag, "_issued"}, issued, TOTAL);
        check({tag, "_addr_order_errs"}, addr_err, 0);
        check({tag, "_beats"}, beats, v.exp_beats);
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i * 3)) bad++;
        check({tag, "_data_errs"}, bad, 0);
        check({tag, "_last_count"}, last_cnt, 1);
        check({tag, "_last_index"}, last_idx, TOTAL - 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_latency"}, done_cyc - last_cyc, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 1);
        check({tag, "_stable_errs"}, stable_err, 0);
        check({tag, "_inflight_le_depth"}, (max_inflight <= FD), 1);
        check({tag, "_error"}, error_o, v.exp_err);
    endtask

    initial begin
        //         lmin lmax rr sf sl spur smid err beats
        vecs[0] = '{1, 1, 0, 0, 0,  0, 0, 0, 16};
        vecs[1] = '{1, 1, 0, 5, 10, 0, 0, 0, 16};
        vecs[2] = '{1, 3, 1, 0, 0,  0, 0, 0, 16};
        vecs[3] = '{1, 1, 0, 0, 0,  1, 0, 1, 16};
        vecs[4] = '{2, 2, 0, 0, 0,  0, 1, 0, 16};

        rstn_i = 1'b0;
        start_i = 1'b0;
        collection_complete_i = 1'b0;
        mem_read_valid_i = 1'b0;
        mem_read_data_i = '0;
        m_ready_i = 1'b1;
        lat_min = 1; lat_max = 1; rand_ready = 0;
        stall_from = 0; stall_len = 0; inject_spur = 0;
        clear_model();
        #1;
        check("reset_outputs",
              {mem_read_enable_o, mem_read_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, error_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (i > 0 && vecs[i-1].exp_err) check("err_sticky_in_idle", error_o, 1);
            do_run(vecs[i], i);
        end

        // Abort mid-run with reset, late responses still in flight.
        clear_model();
        lat_min = 3; lat_max = 3; rand_ready = 0; stall_len = 0; inject_spur = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        collection_complete_i = 1'b1;
        for (int i = 0; i < 200 && beats < 5; i++) tick();
        check("abort_reached_5_beats", beats, 5);
        collection_complete_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        check("abort_outputs_zero",
              {mem_read_enable_o, mem_read_addr_o, m_valid_o, m_data_o, m_last_o, busy_o, done_o, error_o}, 0);
        tick();
        rstn_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("late_valid_ignored_in_idle", error_o, 0);
        check("abort_idle", busy_o, 0);

        // Fresh run after the abort starts again at address 0.
        do_run(vecs[0], 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
